// File: rtl/axi_uart_pkg.sv
// Shared constants for the AXI UART TX slave.
// Register map, response codes, STATUS layout and FSM encodings.
package axi_uart_pkg;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_LEVEL = 8;

  localparam int CTRL_TX_EN  = 0;
  localparam int CTRL_IRQ_EN = 1;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wstate_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rstate_e;

  function automatic logic [31:0] status_word(
    input logic       full,
    input logic       empty,
    input logic [4:0] level
  );
    logic [31:0] w;
    w = '0;
    w[ST_FULL]          = full;
    w[ST_EMPTY]         = empty;
    w[ST_LEVEL +: 5]    = level;
    return w;
  endfunction

endpackage

// File: rtl/axi_uart_tx_slave_if.sv
// AXI4 single-beat bus bundle for the UART TX slave.
// master drives requests, slave drives ready/response.
interface axi_uart_tx_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
);
  logic [ID_WIDTH-1:0]   S_AWID;
  logic [ADDR_WIDTH-1:0] S_AWADDR;
  logic [7:0]            S_AWLEN;
  logic                  S_AWVALID;
  logic                  S_AWREADY;

  logic [DATA_WIDTH-1:0] S_WDATA;
  logic [3:0]            S_WSTRB;
  logic                  S_WLAST;
  logic                  S_WVALID;
  logic                  S_WREADY;

  logic [ID_WIDTH-1:0]   S_BID;
  logic [1:0]            S_BRESP;
  logic                  S_BVALID;
  logic                  S_BREADY;

  logic [ID_WIDTH-1:0]   S_ARID;
  logic [ADDR_WIDTH-1:0] S_ARADDR;
  logic [7:0]            S_ARLEN;
  logic                  S_ARVALID;
  logic                  S_ARREADY;

  logic [ID_WIDTH-1:0]   S_RID;
  logic [DATA_WIDTH-1:0] S_RDATA;
  logic [1:0]            S_RRESP;
  logic                  S_RLAST;
  logic                  S_RVALID;
  logic                  S_RREADY;

  modport slave (
    input  S_AWID, S_AWADDR, S_AWLEN, S_AWVALID,
    output S_AWREADY,
    input  S_WDATA, S_WSTRB, S_WLAST, S_WVALID,
    output S_WREADY,
    output S_BID, S_BRESP, S_BVALID,
    input  S_BREADY,
    input  S_ARID, S_ARADDR, S_ARLEN, S_ARVALID,
    output S_ARREADY,
    output S_RID, S_RDATA, S_RRESP, S_RLAST, S_RVALID,
    input  S_RREADY
  );

  modport master (
    output S_AWID, S_AWADDR, S_AWLEN, S_AWVALID,
    input  S_AWREADY,
    output S_WDATA, S_WSTRB, S_WLAST, S_WVALID,
    input  S_WREADY,
    input  S_BID, S_BRESP, S_BVALID,
    output S_BREADY,
    output S_ARID, S_ARADDR, S_ARLEN, S_ARVALID,
    input  S_ARREADY,
    input  S_RID, S_RDATA, S_RRESP, S_RLAST, S_RVALID,
    output S_RREADY
  );
endinterface

// File: rtl/axi_uart_tx_fifo.sv
// Synchronous FIFO holding TX bytes; DEPTH must be a power of 2.
// Pointers wrap naturally; level carries one extra bit for full.
module axi_uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_level   = r_count;
  assign o_data    = r_mem[r_rptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Storage array; contents need no reset, the count gates reads.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_data;
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/axi_uart_tx_slave.sv
// AXI4 slave for the UART TX region: TXDATA FIFO, STATUS, CTRL.
// Optional tx_irq output when AXI_UART_TX_IRQ_EN is defined.
module axi_uart_tx_slave
  import axi_uart_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int BAUD_DIV   = 16
) (
  input  logic                ACLK,
  input  logic                ARESETN,
  axi_uart_tx_slave_if.slave  s_axi,
  output logic                uart_tx_valid,
  output logic [7:0]          uart_tx_byte
`ifdef AXI_UART_TX_IRQ_EN
  ,
  output logic                tx_irq
`endif
);
  localparam int LW   = $clog2(FIFO_DEPTH) + 1;
  localparam int DIVW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(BAUD_DIV - 1);

  wstate_e               r_wstate;
  wstate_e               w_wstate_nxt;
  logic                  w_awready;
  logic                  w_wready;
  logic                  w_bvalid;
  logic [ID_WIDTH-1:0]   r_awid;
  logic [1:0]            r_awreg;
  logic                  r_awburst;
  logic [1:0]            r_bresp;

  rstate_e               r_rstate;
  rstate_e               w_rstate_nxt;
  logic                  w_arready;
  logic                  w_rvalid;
  logic [ID_WIDTH-1:0]   r_rid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_rresp;
  logic                  r_rlast;
  logic [7:0]            r_rcnt;
  logic [DATA_WIDTH-1:0] w_regdata;

  logic [1:0]            r_ctrl;
  logic [DIVW-1:0]       r_div;
  logic                  r_txv;
  logic [7:0]            r_txb;

  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_ar_hs;
  logic                  w_r_hs;
  logic                  w_wsingle;
  logic                  w_push_req;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_drain_on;
  logic                  w_full;
  logic                  w_empty;
  logic [LW-1:0]         w_level;
  logic [7:0]            w_fifo_data;
  logic                  w_unused;

  assign w_aw_hs    = s_axi.S_AWVALID && w_awready;
  assign w_w_hs     = s_axi.S_WVALID && w_wready;
  assign w_ar_hs    = s_axi.S_ARVALID && w_arready;
  assign w_r_hs     = s_axi.S_RREADY && w_rvalid;
  assign w_wsingle  = w_w_hs && !r_awburst && s_axi.S_WSTRB[0];
  assign w_push_req = w_wsingle && (r_awreg == REG_TXDATA);
  assign w_push     = w_push_req && !w_full;
  assign w_drain_on = r_ctrl[CTRL_TX_EN] && !w_empty;
  assign w_pop      = w_drain_on && (r_div == DIV_LAST);

  assign s_axi.S_AWREADY = w_awready;
  assign s_axi.S_WREADY  = w_wready;
  assign s_axi.S_BVALID  = w_bvalid;
  assign s_axi.S_BID     = r_awid;
  assign s_axi.S_BRESP   = r_bresp;
  assign s_axi.S_ARREADY = w_arready;
  assign s_axi.S_RVALID  = w_rvalid;
  assign s_axi.S_RID     = r_rid;
  assign s_axi.S_RDATA   = r_rdata;
  assign s_axi.S_RRESP   = r_rresp;
  assign s_axi.S_RLAST   = r_rlast;
  assign uart_tx_valid   = r_txv;
  assign uart_tx_byte    = r_txb;

  // Only ADDR[3:2], WDATA[7:0] and WSTRB[0] carry meaning here.
  assign w_unused = ^{s_axi.S_AWADDR[ADDR_WIDTH-1:4],
                      s_axi.S_AWADDR[1:0],
                      s_axi.S_ARADDR[ADDR_WIDTH-1:4],
                      s_axi.S_ARADDR[1:0],
                      s_axi.S_WDATA[DATA_WIDTH-1:8],
                      s_axi.S_WSTRB[3:1]};

  axi_uart_tx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (ACLK),
    .i_rst_n (ARESETN),
    .i_push  (w_push),
    .i_data  (s_axi.S_WDATA[7:0]),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  // Write FSM state register.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) r_wstate <= W_IDLE;
    else          r_wstate <= w_wstate_nxt;
  end

  // Write FSM next state and channel readiness.
  always_comb begin
    w_wstate_nxt = r_wstate;
    w_awready    = 1'b0;
    w_wready     = 1'b0;
    w_bvalid     = 1'b0;
    unique case (r_wstate)
      W_IDLE: begin
        w_awready = 1'b1;
        if (s_axi.S_AWVALID) w_wstate_nxt = W_DATA;
      end
      W_DATA: begin
        w_wready = 1'b1;
        if (s_axi.S_WVALID && s_axi.S_WLAST) w_wstate_nxt = W_RESP;
      end
      W_RESP: begin
        w_bvalid = 1'b1;
        if (s_axi.S_BREADY) w_wstate_nxt = W_IDLE;
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  // Latch AW attributes and build the B response.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_awid    <= '0;
      r_awreg   <= '0;
      r_awburst <= 1'b0;
      r_bresp   <= RESP_OKAY;
    end else if (w_aw_hs) begin
      r_awid    <= s_axi.S_AWID;
      r_awreg   <= s_axi.S_AWADDR[3:2];
      r_awburst <= |s_axi.S_AWLEN;
      r_bresp   <= (|s_axi.S_AWLEN) ? RESP_SLVERR : RESP_OKAY;
    end else if (w_push_req && w_full) begin
      r_bresp   <= RESP_SLVERR;
    end
  end

  // CTRL register; reset leaves the transmitter enabled.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_ctrl <= 2'b01;
    end else if (w_wsingle && (r_awreg == REG_CTRL)) begin
      r_ctrl <= s_axi.S_WDATA[1:0];
    end
  end

  // Read FSM state register.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) r_rstate <= R_IDLE;
    else          r_rstate <= w_rstate_nxt;
  end

  // Read FSM next state and channel readiness.
  always_comb begin
    w_rstate_nxt = r_rstate;
    w_arready    = 1'b0;
    w_rvalid     = 1'b0;
    unique case (r_rstate)
      R_IDLE: begin
        w_arready = 1'b1;
        if (s_axi.S_ARVALID) w_rstate_nxt = R_DATA;
      end
      R_DATA: begin
        w_rvalid = 1'b1;
        if (s_axi.S_RREADY && r_rlast) w_rstate_nxt = R_IDLE;
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  // Register file read mux.
  always_comb begin
    w_regdata = '0;
    unique case (s_axi.S_ARADDR[3:2])
      REG_STATUS: w_regdata = status_word(w_full, w_empty, 5'(w_level));
      REG_CTRL:   w_regdata = {{(DATA_WIDTH-2){1'b0}}, r_ctrl};
      REG_TXDATA,
      REG_RSVD:   w_regdata = '0;
      default:    w_regdata = '0;
    endcase
  end

  // R payload is captured up front so it holds under backpressure.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_rid   <= '0;
      r_rdata <= '0;
      r_rresp <= RESP_OKAY;
      r_rlast <= 1'b0;
      r_rcnt  <= '0;
    end else if (w_ar_hs) begin
      r_rid   <= s_axi.S_ARID;
      r_rcnt  <= s_axi.S_ARLEN;
      r_rlast <= (s_axi.S_ARLEN == 8'd0);
      r_rresp <= (|s_axi.S_ARLEN) ? RESP_SLVERR : RESP_OKAY;
      r_rdata <= (|s_axi.S_ARLEN) ? '0 : w_regdata;
    end else if (w_r_hs && !r_rlast) begin
      r_rcnt  <= r_rcnt - 8'd1;
      r_rlast <= (r_rcnt == 8'd1);
    end
  end

  // Baud divider runs only while there is something to send.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN)        r_div <= '0;
    else if (!w_drain_on) r_div <= '0;
    else if (w_pop)      r_div <= '0;
    else                 r_div <= r_div + 1'b1;
  end

  // One-cycle strobe carrying the byte popped on the previous cycle.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_txv <= 1'b0;
      r_txb <= '0;
    end else begin
      r_txv <= w_pop;
      if (w_pop) r_txb <= w_fifo_data;
    end
  end

`ifdef AXI_UART_TX_IRQ_EN
  logic r_irq;

  // Level interrupt: FIFO drained and interrupts enabled.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) r_irq <= 1'b0;
    else          r_irq <= r_ctrl[CTRL_IRQ_EN] && w_empty;
  end

  assign tx_irq = r_irq;
`endif
endmodule

// File: tb/tb_axi_uart_tx_slave.sv
// Self-checking bench for axi_uart_tx_slave.
// Random bytes/IDs against a queue-based model of the TX path.
module tb_axi_uart_tx_slave;
  localparam int BAUD = 4;
  localparam int DEPTH = 16;
  localparam int TO = 200;

  logic ACLK = 1'b0;
  logic ARESETN = 1'b0;
  logic uart_tx_valid;
  logic [7:0] uart_tx_byte;
`ifdef AXI_UART_TX_IRQ_EN
  logic tx_irq;
`endif

  axi_uart_tx_slave_if #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4)
  ) bus ();

  axi_uart_tx_slave #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4),
    .FIFO_DEPTH(DEPTH), .BAUD_DIV(BAUD)
  ) dut (
    .ACLK          (ACLK),
    .ARESETN       (ARESETN),
    .s_axi         (bus),
    .uart_tx_valid (uart_tx_valid),
    .uart_tx_byte  (uart_tx_byte)
`ifdef AXI_UART_TX_IRQ_EN
    ,
    .tx_irq        (tx_irq)
`endif
  );

  always #5 ACLK = ~ACLK;

  int cyc = 0;
  int tests = 0;
  int fails = 0;
  logic [7:0] mon_q[$];
  int mon_t[$];

  always @(posedge ACLK) cyc <= cyc + 1;

  always @(negedge ACLK) begin
    if (uart_tx_valid === 1'b1) begin
      mon_q.push_back(uart_tx_byte);
      mon_t.push_back(cyc);
    end
  end

  logic [31:0] rd_data [16];
  logic [1:0]  rd_resp [16];
  logic        rd_last [16];
  logic [3:0]  rd_id   [16];
  int          rd_lat;

  localparam logic [31:0] A_TX = 32'h8000_0000;
  localparam logic [31:0] A_ST = 32'h8000_0004;
  localparam logic [31:0] A_CT = 32'h8000_0008;
  localparam logic [31:0] A_RS = 32'h8000_000C;

  task automatic axi_write(
    input  logic [31:0] addr, input logic [3:0] id,
    input  logic [7:0] len, input logic [31:0] data,
    input  logic [3:0] strb,
    output logic [1:0] resp, output logic [3:0] bid,
    output int beats, output int hs_cyc
  );
    int n;
    resp = 2'bxx; bid = 4'bxxxx; beats = 0; hs_cyc = -1;
    @(posedge ACLK); #1;
    bus.S_AWID = id; bus.S_AWADDR = addr;
    bus.S_AWLEN = len; bus.S_AWVALID = 1'b1;
    n = 0;
    while (n < TO) begin
      @(negedge ACLK);
      if (bus.S_AWREADY) break;
      n++;
    end
    @(posedge ACLK); #1;
    bus.S_AWVALID = 1'b0;
    if (n >= TO) begin beats = -1; return; end
    for (int b = 0; b <= int'(len); b++) begin
      bus.S_WDATA = data; bus.S_WSTRB = strb;
      bus.S_WLAST = (b == int'(len)); bus.S_WVALID = 1'b1;
      n = 0;
      while (n < TO) begin
        @(negedge ACLK);
        if (bus.S_WREADY) break;
        n++;
      end
      if (n >= TO) begin
        bus.S_WVALID = 1'b0; beats = -1; return;
      end
      if (bus.S_WLAST) hs_cyc = cyc;
      beats++;
      @(posedge ACLK); #1;
    end
    bus.S_WVALID = 1'b0; bus.S_WLAST = 1'b0;
    bus.S_BREADY = 1'b1;
    n = 0;
    while (n < TO) begin
      @(negedge ACLK);
      if (bus.S_BVALID) break;
      n++;
    end
    if (n < TO) begin resp = bus.S_BRESP; bid = bus.S_BID; end
    else beats = -1;
    @(posedge ACLK); #1;
    bus.S_BREADY = 1'b0;
  endtask

  task automatic axi_read(
    input logic [31:0] addr, input logic [3:0] id,
    input logic [7:0] len, output int beats
  );
    int n;
    beats = 0; rd_lat = -1;
    @(posedge ACLK); #1;
    bus.S_ARID = id; bus.S_ARADDR = addr;
    bus.S_ARLEN = len; bus.S_ARVALID = 1'b1;
    n = 0;
    while (n < TO) begin
      @(negedge ACLK);
      if (bus.S_ARREADY) break;
      n++;
    end
    @(posedge ACLK); #1;
    bus.S_ARVALID = 1'b0;
    if (n >= TO) return;
    bus.S_RREADY = 1'b1;
    n = 0;
    while (n < TO && beats < 16) begin
      @(negedge ACLK);
      n++;
      if (bus.S_RVALID) begin
        if (beats == 0) rd_lat = n;
        rd_data[beats] = bus.S_RDATA;
        rd_resp[beats] = bus.S_RRESP;
        rd_last[beats] = bus.S_RLAST;
        rd_id[beats]   = bus.S_RID;
        beats++;
        if (bus.S_RLAST) break;
      end
    end
    @(posedge ACLK); #1;
    bus.S_RREADY = 1'b0;
  endtask

  task automatic wait_strobes(input int n, input int budget);
    int k;
    k = 0;
    while (mon_q.size() < n && k < budget) begin
      @(negedge ACLK);
      k++;
    end
  endtask

  task automatic test_reset();
    int nb;
    ARESETN = 1'b0;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    ARESETN = 1'b1;
    @(negedge ACLK);
    tests++;
    if ({bus.S_AWREADY, bus.S_ARREADY} !== 2'b11) begin
      fails++;
      $display("FAIL reset_ready got %b want 11",
               {bus.S_AWREADY, bus.S_ARREADY});
    end
    tests++;
    if ({bus.S_WREADY, bus.S_BVALID, bus.S_RVALID, uart_tx_valid,
         bus.S_RLAST} !== 5'b0) begin
      fails++;
      $display("FAIL reset_valids got %b want 00000",
               {bus.S_WREADY, bus.S_BVALID, bus.S_RVALID,
                uart_tx_valid, bus.S_RLAST});
    end
    tests++;
    if ({bus.S_RDATA, bus.S_BRESP, bus.S_RRESP, uart_tx_byte}
        !== 44'h0) begin
      fails++;
      $display("FAIL reset_payload got rdata=%h byte=%h want 0",
               bus.S_RDATA, uart_tx_byte);
    end
    axi_read(A_CT, 4'h3, 8'd0, nb);
    tests++;
    if (nb != 1 || rd_data[0] !== 32'h1) begin
      fails++;
      $display("FAIL reset_ctrl got %h beats=%0d want 1", rd_data[0], nb);
    end
  endtask

  task automatic test_status();
    int nb;
    logic [3:0] id;
    id = 4'($urandom);
    axi_read(A_ST, id, 8'd0, nb);
    tests++;
    if (nb != 1 || rd_data[0] !== 32'h2 || rd_resp[0] !== 2'b00 ||
        rd_last[0] !== 1'b1 || rd_id[0] !== id) begin
      fails++;
      $display("FAIL status_empty got d=%h r=%b l=%b id=%h n=%0d want 2/00/1/%h/1",
               rd_data[0], rd_resp[0], rd_last[0], rd_id[0], nb, id);
    end
    tests++;
    if (rd_lat != 1) begin
      fails++;
      $display("FAIL status_latency got %0d want 1", rd_lat);
    end
  endtask

  task automatic test_drain();
    logic [7:0] exp[$];
    logic [1:0] resp;
    logic [3:0] bid, id;
    int nb, hs, bad;
    axi_write(A_CT, 4'h1, 8'd0, 32'h0, 4'hF, resp, bid, nb, hs);
    exp = '{8'h41, 8'h42};
    for (int i = 0; i < 3; i++) exp.push_back(8'($urandom));
    bad = 0;
    foreach (exp[i]) begin
      id = 4'($urandom);
      axi_write(A_TX, id, 8'd0, {24'($urandom), exp[i]}, 4'h1,
                resp, bid, nb, hs);
      if (resp !== 2'b00 || bid !== id) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL drain_bresp got %0d bad responses want 0", bad);
    end
    axi_read(A_ST, 4'h2, 8'd0, nb);
    tests++;
    if (rd_data[0] !== 32'h0000_0500) begin
      fails++;
      $display("FAIL drain_level got %h want 00000500", rd_data[0]);
    end
    mon_q.delete(); mon_t.delete();
    axi_write(A_CT, 4'h1, 8'd0, 32'h1, 4'h1, resp, bid, nb, hs);
    wait_strobes(exp.size(), 400);
    tests++;
    if (mon_q.size() != exp.size()) begin
      fails++;
      $display("FAIL drain_count got %0d want %0d", mon_q.size(), exp.size());
    end else begin
      bad = 0;
      foreach (exp[i]) begin
        if (mon_q[i] !== exp[i]) bad++;
        if (i > 0 && mon_t[i] - mon_t[i-1] != BAUD) bad++;
      end
      tests++;
      if (bad != 0) begin
        fails++;
        $display("FAIL drain_order got %0d byte/spacing errors want 0", bad);
      end
    end
  endtask

  task automatic test_latency();
    logic [1:0] resp;
    logic [3:0] bid;
    logic [7:0] b;
    int nb, hs;
    repeat (4) @(posedge ACLK);
    mon_q.delete(); mon_t.delete();
    b = 8'($urandom);
    axi_write(A_TX, 4'h5, 8'd0, {24'h0, b}, 4'h1, resp, bid, nb, hs);
    wait_strobes(1, 100);
    tests++;
    if (mon_q.size() != 1 || mon_q[0] !== b ||
        mon_t[0] - hs != BAUD + 1) begin
      fails++;
      $display("FAIL first_latency got n=%0d lat=%0d want n=1 lat=%0d byte=%h",
               mon_q.size(), (mon_t.size() > 0) ? mon_t[0] - hs : -1,
               BAUD + 1, b);
    end
  endtask

  task automatic test_full();
    logic [7:0] exp[$];
    logic [7:0] b;
    logic [1:0] resp, want;
    logic [3:0] bid;
    int nb, hs, bad;
    axi_write(A_CT, 4'h1, 8'd0, 32'h0, 4'h1, resp, bid, nb, hs);
    bad = 0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      b = 8'($urandom);
      want = (exp.size() < DEPTH) ? 2'b00 : 2'b10;
      if (exp.size() < DEPTH) exp.push_back(b);
      axi_write(A_TX, 4'h7, 8'd0, {24'h0, b}, 4'h1, resp, bid, nb, hs);
      if (resp !== want) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL full_bresp got %0d wrong responses want 0", bad);
    end
    axi_read(A_ST, 4'h2, 8'd0, nb);
    tests++;
    if (rd_data[0] !== 32'h0000_1001) begin
      fails++;
      $display("FAIL full_status got %h want 00001001", rd_data[0]);
    end
    mon_q.delete(); mon_t.delete();
    axi_write(A_CT, 4'h1, 8'd0, 32'h1, 4'h1, resp, bid, nb, hs);
    wait_strobes(DEPTH, 400);
    bad = 0;
    foreach (exp[i]) if (i >= mon_q.size() || mon_q[i] !== exp[i]) bad++;
    tests++;
    if (mon_q.size() != DEPTH || bad != 0) begin
      fails++;
      $display("FAIL full_drain got n=%0d errs=%0d want n=%0d errs=0",
               mon_q.size(), bad, DEPTH);
    end
  endtask

  task automatic test_regs();
    logic [1:0] resp;
    logic [3:0] bid;
    int nb, hs;
    axi_write(A_RS, 4'h9, 8'd0, 32'hFFFF_FFFF, 4'hF, resp, bid, nb, hs);
    axi_read(A_RS, 4'h9, 8'd0, nb);
    tests++;
    if (resp !== 2'b00 || rd_data[0] !== 32'h0) begin
      fails++;
      $display("FAIL rsvd got bresp=%b rdata=%h want 00/0", resp, rd_data[0]);
    end
    axi_write(A_TX, 4'hA, 8'd0, 32'h55, 4'hE, resp, bid, nb, hs);
    axi_read(A_ST, 4'hA, 8'd0, nb);
    tests++;
    if (resp !== 2'b00 || rd_data[0] !== 32'h2) begin
      fails++;
      $display("FAIL nostrb got bresp=%b status=%h want 00/2", resp, rd_data[0]);
    end
    axi_read(A_TX, 4'hB, 8'd0, nb);
    tests++;
    if (rd_data[0] !== 32'h0) begin
      fails++;
      $display("FAIL txdata_read got %h want 0", rd_data[0]);
    end
    axi_write(A_CT, 4'hC, 8'd0, 32'h3, 4'h1, resp, bid, nb, hs);
    axi_write(A_CT, 4'hC, 8'd0, 32'h0, 4'hE, resp, bid, nb, hs);
    axi_read(A_CT, 4'hC, 8'd0, nb);
    tests++;
    if (rd_data[0] !== 32'h3) begin
      fails++;
      $display("FAIL ctrl_strb got %h want 3", rd_data[0]);
    end
    axi_write(A_CT, 4'hC, 8'd0, 32'h1, 4'h1, resp, bid, nb, hs);
  endtask

  task automatic test_burst();
    logic [1:0] resp;
    logic [3:0] bid, id;
    int nb, hs, bad;
    mon_q.delete();
    id = 4'($urandom);
    axi_write(A_TX, id, 8'd3, 32'hA5, 4'hF, resp, bid, nb, hs);
    tests++;
    if (nb != 4 || resp !== 2'b10 || bid !== id) begin
      fails++;
      $display("FAIL wburst got beats=%0d bresp=%b bid=%h want 4/10/%h",
               nb, resp, bid, id);
    end
    axi_write(A_CT, id, 8'd1, 32'h0, 4'hF, resp, bid, nb, hs);
    repeat (3 * BAUD) @(negedge ACLK);
    axi_read(A_CT, 4'h1, 8'd0, nb);
    tests++;
    if (mon_q.size() != 0 || rd_data[0] !== 32'h1) begin
      fails++;
      $display("FAIL wburst_effects got strobes=%0d ctrl=%h want 0/1",
               mon_q.size(), rd_data[0]);
    end
    id = 4'($urandom);
    axi_read(A_CT, id, 8'd1, nb);
    bad = 0;
    for (int i = 0; i < 2; i++) begin
      if (rd_data[i] !== 32'h0 || rd_resp[i] !== 2'b10) bad++;
      if (rd_id[i] !== id) bad++;
    end
    tests++;
    if (nb != 2 || bad != 0 || rd_last[0] !== 1'b0 || rd_last[1] !== 1'b1)
    begin
      fails++;
      $display("FAIL rburst got beats=%0d errs=%0d last=%b%b want 2/0/01",
               nb, bad, rd_last[0], rd_last[1]);
    end
  endtask

  task automatic test_backpressure();
    int bad, n;
    logic [3:0] id;
    id = 4'($urandom);
    @(posedge ACLK); #1;
    bus.S_AWID = id; bus.S_AWADDR = A_CT;
    bus.S_AWLEN = 8'd0; bus.S_AWVALID = 1'b1;
    @(negedge ACLK);
    @(posedge ACLK); #1;
    bus.S_AWVALID = 1'b0;
    bus.S_WDATA = 32'h1; bus.S_WSTRB = 4'h1;
    bus.S_WLAST = 1'b1; bus.S_WVALID = 1'b1;
    @(negedge ACLK);
    @(posedge ACLK); #1;
    bus.S_WVALID = 1'b0; bus.S_WLAST = 1'b0;
    n = 0;
    do begin @(negedge ACLK); n++; end
    while (!bus.S_BVALID && n < TO);
    bad = 0;
    repeat (10) begin
      if (bus.S_BVALID !== 1'b1 || bus.S_BID !== id ||
          bus.S_BRESP !== 2'b00 || bus.S_AWREADY !== 1'b0) bad++;
      @(negedge ACLK);
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL b_hold got %0d unstable cycles want 0", bad);
    end
    bus.S_BREADY = 1'b1;
    @(posedge ACLK); #1;
    bus.S_BREADY = 1'b0;
    @(negedge ACLK);
    tests++;
    if (bus.S_AWREADY !== 1'b1 || bus.S_BVALID !== 1'b0) begin
      fails++;
      $display("FAIL b_release got awready=%b bvalid=%b want 1/0",
               bus.S_AWREADY, bus.S_BVALID);
    end
    id = 4'($urandom);
    @(posedge ACLK); #1;
    bus.S_ARID = id; bus.S_ARADDR = A_CT;
    bus.S_ARLEN = 8'd0; bus.S_ARVALID = 1'b1;
    @(negedge ACLK);
    @(posedge ACLK); #1;
    bus.S_ARVALID = 1'b0;
    @(negedge ACLK);
    bad = 0;
    repeat (10) begin
      if (bus.S_RVALID !== 1'b1 || bus.S_RID !== id ||
          bus.S_RDATA !== 32'h1 || bus.S_RRESP !== 2'b00 ||
          bus.S_RLAST !== 1'b1 || bus.S_ARREADY !== 1'b0) bad++;
      @(negedge ACLK);
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL r_hold got %0d unstable cycles want 0", bad);
    end
    bus.S_RREADY = 1'b1;
    @(posedge ACLK); #1;
    bus.S_RREADY = 1'b0;
    @(negedge ACLK);
    tests++;
    if (bus.S_ARREADY !== 1'b1 || bus.S_RVALID !== 1'b0) begin
      fails++;
      $display("FAIL r_release got arready=%b rvalid=%b want 1/0",
               bus.S_ARREADY, bus.S_RVALID);
    end
  endtask

  task automatic test_reset_abort();
    logic [1:0] resp;
    logic [3:0] bid;
    int nb, hs, bv;
    axi_write(A_CT, 4'h1, 8'd0, 32'h0, 4'h1, resp, bid, nb, hs);
    for (int i = 0; i < 3; i++)
      axi_write(A_TX, 4'h2, 8'd0, 32'($urandom), 4'h1, resp, bid, nb, hs);
    @(posedge ACLK); #1;
    bus.S_AWID = 4'h6; bus.S_AWADDR = A_TX;
    bus.S_AWLEN = 8'd0; bus.S_AWVALID = 1'b1;
    @(negedge ACLK);
    @(posedge ACLK); #1;
    bus.S_AWVALID = 1'b0;
    @(negedge ACLK);
    tests++;
    if (bus.S_WREADY !== 1'b1) begin
      fails++;
      $display("FAIL abort_wdata got wready=%b want 1", bus.S_WREADY);
    end
    #2;
    ARESETN = 1'b0;
    #1;
    tests++;
    if ({bus.S_AWREADY, bus.S_WREADY, bus.S_BVALID, uart_tx_valid}
        !== 4'b1000) begin
      fails++;
      $display("FAIL abort_inreset got %b want 1000",
               {bus.S_AWREADY, bus.S_WREADY, bus.S_BVALID, uart_tx_valid});
    end
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    ARESETN = 1'b1;
    mon_q.delete();
    bus.S_BREADY = 1'b1;
    bv = 0;
    repeat (20) begin
      @(negedge ACLK);
      if (bus.S_BVALID) bv++;
    end
    bus.S_BREADY = 1'b0;
    tests++;
    if (bv != 0 || mon_q.size() != 0) begin
      fails++;
      $display("FAIL abort_quiet got bvalid=%0d strobes=%0d want 0/0",
               bv, mon_q.size());
    end
    axi_read(A_ST, 4'h4, 8'd0, nb);
    tests++;
    if (rd_data[0] !== 32'h2) begin
      fails++;
      $display("FAIL abort_status got %h want 2", rd_data[0]);
    end
  endtask

  initial begin
    bus.S_AWID = '0; bus.S_AWADDR = '0; bus.S_AWLEN = '0;
    bus.S_AWVALID = 1'b0;
    bus.S_WDATA = '0; bus.S_WSTRB = '0; bus.S_WLAST = 1'b0;
    bus.S_WVALID = 1'b0; bus.S_BREADY = 1'b0;
    bus.S_ARID = '0; bus.S_ARADDR = '0; bus.S_ARLEN = '0;
    bus.S_ARVALID = 1'b0; bus.S_RREADY = 1'b0;
    test_reset();
    test_status();
    test_drain();
    test_latency();
    test_full();
    test_regs();
    test_burst();
    test_backpressure();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
